// File: rtl/playback_scheduler.sv
// Step/loop scheduler for a PS/2-keyboard-driven sequencer: start/pause/stop keys, tempo ticks, loop counting.
// Optional build macro LOOP_INFINITE_EN: a latched loop target of 0 plays forever and loop_cnt wraps 99->0.
module playback_scheduler #(
  parameter int          NUM_STEPS = 16,
  parameter logic [7:0]  KEY_PLAY  = 8'h29,
  parameter logic [7:0]  KEY_STOP  = 8'h76
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [7:0] data,
  input  logic       data_en,
  input  logic       tick,
  input  logic [6:0] Loops,
  input  logic       set,
  output logic [3:0] step,
  output logic [6:0] loop_cnt,
  output logic       step_pulse,
  output logic       playing,
  output logic       done
);

  // state    | meaning
  // STOPPED  | idle, waiting for KEY_PLAY with a committed loop target
  // PLAYING  | advancing one step per tick
  // PAUSED   | step and loop count frozen, ticks ignored
  typedef enum logic [1:0] {S_STOPPED, S_PLAYING, S_PAUSED} state_t;

  localparam logic [3:0] LAST_STEP = 4'(NUM_STEPS - 1);

  state_t     state, state_n;
  logic       brk, brk_n;
  logic [6:0] target, target_n;
  logic [3:0] step_n;
  logic [6:0] loop_n, loop_inc;
  logic       pulse_n, done_n, playing_n;
  logic       is_key, key_play, key_stop;

  always_comb begin
    state_n  = state;
    brk_n    = brk;
    target_n = target;
    step_n   = step;
    loop_n   = loop_cnt;
    pulse_n  = 1'b0;
    done_n   = 1'b0;
    is_key   = 1'b0;

    // Break prefix swallows the following byte; the extended prefix is transparent.
    if (data_en) begin
      if (data == 8'hF0) begin
        brk_n = 1'b1;
      end else if (data != 8'hE0) begin
        if (brk) brk_n = 1'b0;
        else     is_key = 1'b1;
      end
    end
    key_play = is_key && (data == KEY_PLAY);
    key_stop = is_key && (data == KEY_STOP);

`ifdef LOOP_INFINITE_EN
    loop_inc = (loop_cnt == 7'd99) ? 7'd0 : loop_cnt + 7'd1;
`else
    loop_inc = loop_cnt + 7'd1;
`endif

    case (state)
      S_STOPPED: begin
        if (key_play && set) begin
`ifdef LOOP_INFINITE_EN
          target_n = Loops;
`else
          target_n = (Loops == 7'd0) ? 7'd1 : Loops;
`endif
          loop_n  = 7'd0;
          step_n  = 4'd0;
          pulse_n = 1'b1;
          state_n = S_PLAYING;
        end
      end
      S_PLAYING: begin
        if (key_stop) begin
          state_n = S_STOPPED;
          step_n  = 4'd0;
          loop_n  = 7'd0;
        end else if (key_play) begin
          state_n = S_PAUSED;
        end else if (tick && !is_key) begin
          // Any key in the same cycle drops the tick.
          if (step != LAST_STEP) begin
            step_n  = step + 4'd1;
            pulse_n = 1'b1;
          end else begin
            loop_n = loop_inc;
            step_n = 4'd0;
            if (target != 7'd0 && loop_inc == target) begin
              done_n  = 1'b1;
              state_n = S_STOPPED;
            end else begin
              pulse_n = 1'b1;
            end
          end
        end
      end
      S_PAUSED: begin
        if (key_stop) begin
          state_n = S_STOPPED;
          step_n  = 4'd0;
          loop_n  = 7'd0;
        end else if (key_play) begin
          state_n = S_PLAYING;
        end
      end
      default: state_n = S_STOPPED;
    endcase

    playing_n = (state_n == S_PLAYING);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state      <= S_STOPPED;
      brk        <= 1'b0;
      target     <= 7'd1;
      step       <= 4'd0;
      loop_cnt   <= 7'd0;
      step_pulse <= 1'b0;
      done       <= 1'b0;
      playing    <= 1'b0;
    end else begin
      state      <= state_n;
      brk        <= brk_n;
      target     <= target_n;
      step       <= step_n;
      loop_cnt   <= loop_n;
      step_pulse <= pulse_n;
      done       <= done_n;
      playing    <= playing_n;
    end
  end

endmodule

// File: tb/tb_playback_scheduler.sv
// Scoreboard bench for playback_scheduler: directed scenarios plus random keys/ticks against a behavioural model.
module tb_playback_scheduler;

  localparam logic [7:0] KP = 8'h29;
  localparam logic [7:0] KS = 8'h76;
  localparam int         NS = 16;

  logic       Clock, nReset;
  logic [7:0] data;
  logic       data_en, tick, set;
  logic [6:0] Loops;
  logic [3:0] step;
  logic [6:0] loop_cnt;
  logic       step_pulse, playing, done;

  playback_scheduler #(.NUM_STEPS(NS), .KEY_PLAY(KP), .KEY_STOP(KS)) dut (
    .Clock(Clock), .nReset(nReset), .data(data), .data_en(data_en), .tick(tick),
    .Loops(Loops), .set(set), .step(step), .loop_cnt(loop_cnt),
    .step_pulse(step_pulse), .playing(playing), .done(done)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int cyc = 0;
  always @(posedge Clock) cyc++;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
  endtask

  typedef struct {
    int cyc;
    int step;
    int lc;
    int sp;
    int dn;
    int pl;
  } snap_t;
  snap_t sq[$];

  // Reference model: mode 0=stopped, 1=playing, 2=paused
  int m_mode, m_pos, m_lc, m_tgt;
  bit m_brk;
  int lp_v;
  bit set_v;

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_lc = 0; m_tgt = 1; m_brk = 0;
  endtask

  task automatic model(input bit den, input logic [7:0] d, input bit tk, input bit rn, output snap_t s);
    int sp, dn;
    bit key;
    sp = 0; dn = 0; key = 0;
    if (!rn) begin
      model_reset();
    end else begin
      if (den) begin
        if (d == 8'hF0) m_brk = 1;
        else if (d == 8'hE0) key = 0;
        else if (m_brk) m_brk = 0;
        else key = 1;
      end
      if (key && d == KS && m_mode != 0) begin
        m_mode = 0; m_pos = 0; m_lc = 0;
      end else if (key && d == KP) begin
        if (m_mode == 0) begin
          if (set_v) begin
`ifdef LOOP_INFINITE_EN
            m_tgt = lp_v;
`else
            m_tgt = (lp_v == 0) ? 1 : lp_v;
`endif
            m_lc = 0; m_pos = 0; sp = 1; m_mode = 1;
          end
        end else if (m_mode == 1) m_mode = 2;
        else m_mode = 1;
      end else if (!key && tk && m_mode == 1) begin
        if (m_pos < NS - 1) begin
          m_pos++; sp = 1;
        end else begin
`ifdef LOOP_INFINITE_EN
          m_lc = (m_lc + 1) % 100;
`else
          m_lc = m_lc + 1;
`endif
          m_pos = 0;
          if (m_tgt != 0 && m_lc == m_tgt) begin
            dn = 1; m_mode = 0;
          end else sp = 1;
        end
      end
    end
    s.cyc = cyc + 1; s.step = m_pos; s.lc = m_lc; s.sp = sp; s.dn = dn; s.pl = (m_mode == 1);
  endtask

  task automatic drive(input bit den, input logic [7:0] d, input bit tk, input bit rn = 1);
    snap_t s;
    @(negedge Clock);
    nReset = rn; data_en = den; data = d; tick = tk; Loops = 7'(lp_v); set = set_v;
    model(den, d, tk, rn, s);
    sq.push_back(s);
  endtask

  task automatic press(input logic [7:0] b);
    drive(1, b, 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) drive(0, 8'h00, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 8'h00, 0);
  endtask

  initial begin : monitor
    snap_t s;
    forever begin
      @(negedge Clock);
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        s = sq.pop_front();
        chk("missed_slot", cyc, s.cyc);
      end
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        s = sq.pop_front();
        chk("step", int'(step), s.step);
        chk("loop_cnt", int'(loop_cnt), s.lc);
        chk("flags{pulse,done,playing}", int'({step_pulse, done, playing}), (s.sp << 2) | (s.dn << 1) | s.pl);
      end
    end
  end

  initial begin : stim
    snap_t z;
    logic [7:0] b;
    int r;
    nReset = 1'b0; data = 8'h00; data_en = 1'b0; tick = 1'b0; Loops = 7'd0; set = 1'b0;
    lp_v = 0; set_v = 0;
    model_reset();
    #1;
    chk("reset_outputs", int'({step, loop_cnt, step_pulse, playing, done}), 0);
    idle(1);

    // Two full loops ending in done
    set_v = 1; lp_v = 2;
    press(KP);
    ticks(32);
    idle(2);

    // Pause holds step; ticks ignored while paused
    lp_v = 3;
    press(KP);
    ticks(5);
    press(KP);
    ticks(4);
    press(KP);
    ticks(1);
    idle(1);

    // Break code swallows the next key; E0 does not clear the break flag
    press(8'hF0);
    press(KP);
    press(8'hF0);
    press(8'hE0);
    press(KP);
    press(KP);
    idle(1);
    press(KS);
    idle(1);

    // Stop coincident with tick at the loop boundary
    press(KP);
    ticks(31);
    drive(1, KS, 1);
    idle(2);

    // set=0 ignored; Loops=0 behaviour
    set_v = 0; lp_v = 4;
    press(KP);
    idle(1);
    set_v = 1; lp_v = 0;
    press(KP);
`ifdef LOOP_INFINITE_EN
    ticks(NS * 101 + 3);
    press(KS);
`else
    ticks(NS);
`endif
    idle(2);

    // Target is latched: later Loops/set changes are ignored
    lp_v = 1;
    press(KP);
    lp_v = 5; set_v = 0;
    ticks(8);
    press(KP);
    press(KP);
    ticks(8);
    idle(2);

    // Asynchronous reset mid-run at step 9, then restart on the first edge after release
    set_v = 1; lp_v = 5;
    press(KP);
    ticks(9);
    idle(1);
    #2;
    nReset = 1'b0;
    model_reset();
    z = sq[sq.size() - 1];
    z.step = 0; z.lc = 0; z.sp = 0; z.dn = 0; z.pl = 0;
    sq[sq.size() - 1] = z;
    #1;
    chk("async_reset_outputs", int'({step, loop_cnt, step_pulse, playing, done}), 0);
    drive(0, 8'h00, 1, 0);
    drive(1, KP, 0, 0);
    drive(1, KP, 0, 1);
    ticks(2);
    press(KS);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    b = KP;
        2:       b = KS;
        3:       b = 8'hF0;
        4:       b = 8'hE0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 7) == 0) begin
        lp_v = int'($urandom_range(0, 3));
        set_v = ($urandom_range(0, 3) != 0);
      end
      drive($urandom_range(0, 7) == 0, b, $urandom_range(0, 2) == 0);
    end
    idle(2);

    for (int i = 0; i < 10 && sq.size() > 0; i++) @(negedge Clock);
    chk("scoreboard_drained", sq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/playback_scheduler.md
PLAYBACK_SCHEDULER -- requirements
Module: playback_scheduler

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 16, steps per loop (2..16).
REQ-002 SHALL have parameter KEY_PLAY, default 8'h29 (SPACE), start/pause/resume key.
REQ-003 SHALL have parameter KEY_STOP, default 8'h76 (ESC), stop key.
REQ-004 SHALL have port Clock  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port nReset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port data  input  8  PS/2 scan-code byte.
REQ-007 SHALL have port data_en  input  1  one-cycle strobe; data valid when high.
REQ-008 SHALL have port tick  input  1  one-cycle step-rate pulse from the tempo source.
REQ-009 SHALL have port Loops  input  7  loop target, 0..99, from the loop-entry FSM.
REQ-010 SHALL have port set  input  1  high when Loops holds a committed value.
REQ-011 SHALL have port step  output  4  current step index, 0..NUM_STEPS-1.
REQ-012 SHALL have port loop_cnt  output  7  completed loops in the current run.
REQ-013 SHALL have port step_pulse  output  1  one-cycle pulse when step becomes active.
REQ-014 SHALL have port playing  output  1  high in PLAYING.
REQ-015 SHALL have port done  output  1  one-cycle pulse when the run finishes.

Function
REQ-016 SHALL implement states STOPPED, PLAYING, PAUSED; all outputs registered, changing one cycle after the causing input.
REQ-017 SHALL, on data_en with data=8'hF0, set a break flag; the next data_en byte SHALL clear the flag and be ignored; 8'hE0 SHALL be ignored and SHALL NOT clear the flag.
REQ-018 A "key" SHALL be a data_en byte that is not 8'hF0/8'hE0 and not flagged as a break.
REQ-019 STOPPED: KEY_PLAY with set=1 SHALL latch Loops into an internal target, clear loop_cnt, set step=0, pulse step_pulse, enter PLAYING; with set=0 it SHALL be ignored.
REQ-020 PLAYING, tick with step<NUM_STEPS-1: step SHALL increment and step_pulse SHALL pulse.
REQ-021 PLAYING, tick with step=NUM_STEPS-1: loop_cnt SHALL increment; if new loop_cnt equals target, done SHALL pulse, step SHALL go to 0 without step_pulse, state SHALL go to STOPPED, and loop_cnt SHALL hold; otherwise step SHALL go to 0 with step_pulse.
REQ-022 PLAYING: KEY_PLAY SHALL enter PAUSED, holding step and loop_cnt.
REQ-023 PAUSED: tick SHALL be ignored; KEY_PLAY SHALL return to PLAYING at the held step without step_pulse.
REQ-024 PLAYING or PAUSED: KEY_STOP SHALL enter STOPPED with step=0, loop_cnt=0, no done.
REQ-025 Key and tick in the same cycle: the key SHALL win and the tick SHALL be dropped.
REQ-026 Changes on Loops/set during PLAYING or PAUSED SHALL NOT affect the latched target.
REQ-027 Without LOOP_INFINITE_EN, a latched target of 0 SHALL be treated as 1.

Reset
REQ-028 nReset low SHALL immediately force STOPPED, step=0, loop_cnt=0, step_pulse=0, playing=0, done=0, break flag clear, target=1, including mid-run.
REQ-029 The first edge after reset release SHALL be processed normally.

Configuration
REQ-030 Macro LOOP_INFINITE_EN defined: a latched target of 0 SHALL mean infinite play; done never pulses; loop_cnt wraps 99->0.
REQ-031 Macro LOOP_INFINITE_EN undefined: REQ-027 applies and no wrap logic exists.

Verification
REQ-032 set=1, Loops=2, KEY_PLAY, 32 ticks -> step_pulse x32, step 0..15 twice, done one pulse after 32nd tick, loop_cnt=2, playing=0.
REQ-033 Playing at step 5, KEY_PLAY, 4 ticks, KEY_PLAY, 1 tick -> step stays 5 while paused, then 6.
REQ-034 Playing, F0 then 29 on data -> no state change; next bare 29 -> PAUSED.
REQ-035 KEY_STOP coincident with tick at step 15, loop_cnt=1 -> STOPPED, step=0, loop_cnt=0, no done.
REQ-036 set=0, KEY_PLAY -> stays STOPPED; with set=1, Loops=0 -> one loop then done (no macro) or never done with loop_cnt wrap 99->0 (LOOP_INFINITE_EN).
REQ-037 nReset asserted mid-run at step 9 -> all outputs 0 asynchronously; after release, KEY_PLAY restarts from step 0.
